// File: rtl/wb_pkg.sv
// Shared definitions for the Wishbone command master: state encoding,
// default bus widths and the read value reported on a bus timeout.
package wb_pkg;

   localparam int WB_ADDRWIDTH = 17;
   localparam int WB_DATAWIDTH = 32;

   localparam logic [31:0] WB_ERR_READ_VALUE = 32'hBAD_FAB_AC;

   localparam logic [1:0] ST_IDLE = 2'd0;
   localparam logic [1:0] ST_BUS  = 2'd1;
   localparam logic [1:0] ST_RESP = 2'd2;

endpackage : wb_pkg

// File: rtl/wb_ack_timer.sv
// Counts un-ACKed bus cycles; expired_o flags the last allowed cycle so the
// master can abort on the same clock edge the count would reach the limit.
module wb_ack_timer #(
   parameter int TIMEOUT_CYCLES = 7
) (
   input  logic clk_i,
   input  logic rst_ni,
   input  logic clear_i,
   input  logic enable_i,
   output logic expired_o
);

   localparam int CW = 8;
   localparam logic [CW-1:0] LAST = CW'(TIMEOUT_CYCLES - 1);

   logic [CW-1:0] cnt_q;
   logic [CW-1:0] cnt_d;

   always_comb begin
      cnt_d = cnt_q;
      if (clear_i) begin
         cnt_d = '0;
      end else if (enable_i) begin
         cnt_d = cnt_q + 8'd1;
      end
   end

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         cnt_q <= '0;
      end else begin
         cnt_q <= cnt_d;
      end
   end

   assign expired_o = enable_i && (cnt_q == LAST);

endmodule : wb_ack_timer

// File: rtl/wb_cmd_master.sv
// Single-outstanding Wishbone initiator: accepts one command, runs one bus
// cycle (ACK or timeout), then holds the response until it is consumed.
module wb_cmd_master
   import wb_pkg::*;
#(
   parameter int                    ADDRWIDTH      = WB_ADDRWIDTH,
   parameter int                    DATAWIDTH      = WB_DATAWIDTH,
   parameter int                    TIMEOUT_CYCLES = 7,
   parameter logic [DATAWIDTH-1:0]  ERR_READ_VALUE = DATAWIDTH'(WB_ERR_READ_VALUE)
) (
   input  logic                     WB_CLK,
   input  logic                     WB_RST_n,

   // Both cmd and rsp channels use valid/ready: a transfer happens on a
   // rising edge where valid and ready are both high; ready never depends
   // combinationally on valid.
   input  logic                     cmd_valid,
   output logic                     cmd_ready,
   input  logic                     cmd_we,
   input  logic [ADDRWIDTH-1:0]     cmd_adr,
   input  logic [DATAWIDTH/8-1:0]   cmd_be,
   input  logic [DATAWIDTH-1:0]     cmd_wdat,

   output logic                     rsp_valid,
   input  logic                     rsp_ready,
   output logic [DATAWIDTH-1:0]     rsp_rdat,
   output logic                     rsp_err,

   output logic [ADDRWIDTH-1:0]     WBm_ADR,
   output logic                     WBm_CYC,
   output logic                     WBm_STB,
   output logic                     WBm_WE,
   output logic                     WBm_RD,
   output logic [DATAWIDTH/8-1:0]   WBm_BYTE_STB,
   output logic [DATAWIDTH-1:0]     WBm_WR_DAT,
   input  logic [DATAWIDTH-1:0]     WBm_RD_DAT,
   input  logic                     WBm_ACK,

   output logic [1:0]               dbg_state
);

   logic [1:0]             state_q,   state_d;
   logic                   ready_q,   ready_d;
   logic                   cyc_q,     cyc_d;
   logic                   wbm_we_q,  wbm_we_d;
   logic                   rd_q,      rd_d;
   logic                   cmd_we_q,  cmd_we_d;
   logic [ADDRWIDTH-1:0]   adr_q,     adr_d;
   logic [DATAWIDTH/8-1:0] be_q,      be_d;
   logic [DATAWIDTH-1:0]   wdat_q,    wdat_d;
   logic                   rvalid_q,  rvalid_d;
   logic                   rerr_q,    rerr_d;
   logic [DATAWIDTH-1:0]   rdat_q,    rdat_d;

   logic                   tmr_clear;
   logic                   tmr_enable;
   logic                   tmr_expired;

   // Counter sits at zero outside BUS, so every BUS entry starts fresh.
   assign tmr_clear  = (state_q != ST_BUS);
   assign tmr_enable = (state_q == ST_BUS) && !WBm_ACK;

   wb_ack_timer #(
      .TIMEOUT_CYCLES (TIMEOUT_CYCLES)
   ) u_ack_timer (
      .clk_i     (WB_CLK),
      .rst_ni    (WB_RST_n),
      .clear_i   (tmr_clear),
      .enable_i  (tmr_enable),
      .expired_o (tmr_expired)
   );

   always_comb begin
      state_d  = state_q;
      ready_d  = ready_q;
      cyc_d    = cyc_q;
      wbm_we_d = wbm_we_q;
      rd_d     = rd_q;
      cmd_we_d = cmd_we_q;
      adr_d    = adr_q;
      be_d     = be_q;
      wdat_d   = wdat_q;
      rvalid_d = rvalid_q;
      rerr_d   = rerr_q;
      rdat_d   = rdat_q;

      case (state_q)
         ST_IDLE: begin
            ready_d = 1'b1;
            if (cmd_valid && ready_q) begin
               cmd_we_d = cmd_we;
               adr_d    = cmd_adr;
               be_d     = cmd_be;
               wdat_d   = cmd_wdat;
               cyc_d    = 1'b1;
               wbm_we_d = cmd_we;
               rd_d     = ~cmd_we;
               ready_d  = 1'b0;
               state_d  = ST_BUS;
            end
         end

         ST_BUS: begin
            // ACK is tested first so it wins over a coincident timeout.
            if (WBm_ACK) begin
               if (!cmd_we_q) begin
                  rdat_d = WBm_RD_DAT;
               end
               rerr_d   = 1'b0;
               rvalid_d = 1'b1;
               cyc_d    = 1'b0;
               wbm_we_d = 1'b0;
               rd_d     = 1'b0;
               state_d  = ST_RESP;
            end else if (tmr_expired) begin
               rdat_d   = ERR_READ_VALUE;
               rerr_d   = 1'b1;
               rvalid_d = 1'b1;
               cyc_d    = 1'b0;
               wbm_we_d = 1'b0;
               rd_d     = 1'b0;
               state_d  = ST_RESP;
            end
         end

         ST_RESP: begin
            if (rsp_ready) begin
               rvalid_d = 1'b0;
               ready_d  = 1'b1;
               state_d  = ST_IDLE;
            end
         end

         default: begin
            cyc_d    = 1'b0;
            wbm_we_d = 1'b0;
            rd_d     = 1'b0;
            rvalid_d = 1'b0;
            ready_d  = 1'b1;
            state_d  = ST_IDLE;
         end
      endcase
   end

   always_ff @(posedge WB_CLK or negedge WB_RST_n) begin
      if (!WB_RST_n) begin
         state_q  <= ST_IDLE;
         ready_q  <= 1'b0;
         cyc_q    <= 1'b0;
         wbm_we_q <= 1'b0;
         rd_q     <= 1'b0;
         cmd_we_q <= 1'b0;
         adr_q    <= '0;
         be_q     <= '0;
         wdat_q   <= '0;
         rvalid_q <= 1'b0;
         rerr_q   <= 1'b0;
         rdat_q   <= '0;
      end else begin
         state_q  <= state_d;
         ready_q  <= ready_d;
         cyc_q    <= cyc_d;
         wbm_we_q <= wbm_we_d;
         rd_q     <= rd_d;
         cmd_we_q <= cmd_we_d;
         adr_q    <= adr_d;
         be_q     <= be_d;
         wdat_q   <= wdat_d;
         rvalid_q <= rvalid_d;
         rerr_q   <= rerr_d;
         rdat_q   <= rdat_d;
      end
   end

   assign cmd_ready    = ready_q;
   assign rsp_valid    = rvalid_q;
   assign rsp_err      = rerr_q;
   assign rsp_rdat     = rdat_q;
   assign WBm_ADR      = adr_q;
   assign WBm_CYC      = cyc_q;
   assign WBm_STB      = cyc_q;
   assign WBm_WE       = wbm_we_q;
   assign WBm_RD       = rd_q;
   assign WBm_BYTE_STB = be_q;
   assign WBm_WR_DAT   = wdat_q;
   assign dbg_state    = state_q;

endmodule : wb_cmd_master

// File: tb/tb_wb_cmd_master.sv
// Directed bench for wb_cmd_master: write, read, timeout, held response,
// mid-bus reset and back-to-back traffic with hand-computed expectations.
module tb_wb_cmd_master;
   import wb_pkg::*;

   localparam int AW = 17;
   localparam int DW = 32;

   logic            clk = 1'b0;
   logic            rst_n = 1'b0;
   logic            cmd_valid = 1'b0;
   logic            cmd_ready;
   logic            cmd_we = 1'b0;
   logic [AW-1:0]   cmd_adr = '0;
   logic [DW/8-1:0] cmd_be = '0;
   logic [DW-1:0]   cmd_wdat = '0;
   logic            rsp_valid;
   logic            rsp_ready = 1'b0;
   logic [DW-1:0]   rsp_rdat;
   logic            rsp_err;
   logic [AW-1:0]   wbm_adr;
   logic            wbm_cyc, wbm_stb, wbm_we, wbm_rd;
   logic [DW/8-1:0] wbm_be;
   logic [DW-1:0]   wbm_wr_dat;
   logic [DW-1:0]   wbm_rd_dat = '0;
   logic            wbm_ack = 1'b0;
   logic [1:0]      dbg_state;

   int n_cmp = 0;
   int n_err = 0;

   wb_cmd_master #(
      .ADDRWIDTH      (AW),
      .DATAWIDTH      (DW),
      .TIMEOUT_CYCLES (7),
      .ERR_READ_VALUE (32'hBAD_FAB_AC)
   ) dut (
      .WB_CLK       (clk),
      .WB_RST_n     (rst_n),
      .cmd_valid    (cmd_valid),
      .cmd_ready    (cmd_ready),
      .cmd_we       (cmd_we),
      .cmd_adr      (cmd_adr),
      .cmd_be       (cmd_be),
      .cmd_wdat     (cmd_wdat),
      .rsp_valid    (rsp_valid),
      .rsp_ready    (rsp_ready),
      .rsp_rdat     (rsp_rdat),
      .rsp_err      (rsp_err),
      .WBm_ADR      (wbm_adr),
      .WBm_CYC      (wbm_cyc),
      .WBm_STB      (wbm_stb),
      .WBm_WE       (wbm_we),
      .WBm_RD       (wbm_rd),
      .WBm_BYTE_STB (wbm_be),
      .WBm_WR_DAT   (wbm_wr_dat),
      .WBm_RD_DAT   (wbm_rd_dat),
      .WBm_ACK      (wbm_ack),
      .dbg_state    (dbg_state)
   );

   always #5 clk = ~clk;

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_cmp++;
      assert (obs === exp) else begin
         n_err++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic put_cmd(input logic we, input logic [AW-1:0] adr,
                          input logic [DW/8-1:0] be, input logic [DW-1:0] wdat);
      cmd_valid = 1'b1;
      cmd_we    = we;
      cmd_adr   = adr;
      cmd_be    = be;
      cmd_wdat  = wdat;
   endtask

   initial begin
      // Reset state
      tick();
      tick();
      chk("rst_cmd_ready", 64'(cmd_ready), 64'd0);
      chk("rst_cyc", 64'(wbm_cyc), 64'd0);
      chk("rst_stb", 64'(wbm_stb), 64'd0);
      chk("rst_rsp_valid", 64'(rsp_valid), 64'd0);
      chk("rst_rsp_rdat", 64'(rsp_rdat), 64'd0);
      chk("rst_adr", 64'(wbm_adr), 64'd0);
      chk("rst_state", 64'(dbg_state), 64'(ST_IDLE));
      rst_n = 1'b1;
      tick();
      chk("post_rst_cmd_ready", 64'(cmd_ready), 64'd1);

      // Write, ACK on the second BUS cycle
      put_cmd(1'b1, 17'h00008, 4'hF, 32'h1234_5678);
      tick();
      cmd_valid = 1'b0;
      chk("wr_cyc1", 64'(wbm_cyc), 64'd1);
      chk("wr_stb1", 64'(wbm_stb), 64'd1);
      chk("wr_we", 64'(wbm_we), 64'd1);
      chk("wr_rd", 64'(wbm_rd), 64'd0);
      chk("wr_adr", 64'(wbm_adr), 64'h8);
      chk("wr_be", 64'(wbm_be), 64'hF);
      chk("wr_dat", 64'(wbm_wr_dat), 64'h1234_5678);
      chk("wr_cmd_ready_bus", 64'(cmd_ready), 64'd0);
      tick();
      chk("wr_cyc2", 64'(wbm_cyc), 64'd1);
      wbm_ack = 1'b1;
      tick();
      wbm_ack = 1'b0;
      chk("wr_cyc_drop", 64'(wbm_cyc), 64'd0);
      chk("wr_we_drop", 64'(wbm_we), 64'd0);
      chk("wr_rsp_valid", 64'(rsp_valid), 64'd1);
      chk("wr_rsp_err", 64'(rsp_err), 64'd0);
      chk("wr_adr_hold", 64'(wbm_adr), 64'h8);
      rsp_ready = 1'b1;
      tick();
      rsp_ready = 1'b0;
      chk("wr_rsp_done", 64'(rsp_valid), 64'd0);
      chk("wr_idle_ready", 64'(cmd_ready), 64'd1);

      // Read with ACK on the first BUS cycle, then response held 10 cycles
      put_cmd(1'b0, 17'h00000, 4'hF, 32'h0);
      tick();
      cmd_valid = 1'b0;
      chk("rd_rd", 64'(wbm_rd), 64'd1);
      chk("rd_we", 64'(wbm_we), 64'd0);
      chk("rd_cyc", 64'(wbm_cyc), 64'd1);
      wbm_ack    = 1'b1;
      wbm_rd_dat = 32'hFAB_DEF_AC;
      tick();
      chk("rd_rdat", 64'(rsp_rdat), 64'hFAB_DEF_AC);
      chk("rd_err", 64'(rsp_err), 64'd0);
      chk("rd_rd_drop", 64'(wbm_rd), 64'd0);
      put_cmd(1'b1, 17'h1FFFC, 4'h3, 32'hDEAD_BEEF);
      wbm_rd_dat = 32'h5555_AAAA;
      for (int i = 0; i < 10; i++) begin
         tick();
         chk("hold_valid", 64'(rsp_valid), 64'd1);
         chk("hold_rdat", 64'(rsp_rdat), 64'hFAB_DEF_AC);
         chk("hold_cmd_ready", 64'(cmd_ready), 64'd0);
         chk("hold_cyc", 64'(wbm_cyc), 64'd0);
      end
      cmd_valid = 1'b0;
      wbm_ack   = 1'b0;
      rsp_ready = 1'b1;
      tick();
      rsp_ready = 1'b0;
      chk("hold_release_state", 64'(dbg_state), 64'(ST_IDLE));
      chk("hold_adr_unlatched", 64'(wbm_adr), 64'h0);
      chk("hold_rsp_valid", 64'(rsp_valid), 64'd0);

      // Read that times out after 7 un-ACKed BUS cycles
      put_cmd(1'b0, 17'h00010, 4'hF, 32'h0);
      tick();
      cmd_valid = 1'b0;
      for (int i = 0; i < 7; i++) begin
         chk("to_cyc_high", 64'(wbm_cyc), 64'd1);
         tick();
      end
      chk("to_cyc_drop", 64'(wbm_cyc), 64'd0);
      chk("to_rsp_valid", 64'(rsp_valid), 64'd1);
      chk("to_rdat", 64'(rsp_rdat), 64'hBAD_FAB_AC);
      chk("to_err", 64'(rsp_err), 64'd1);
      rsp_ready = 1'b1;
      tick();
      rsp_ready = 1'b0;

      // ACK on the 7th BUS cycle beats the timeout
      put_cmd(1'b0, 17'h00014, 4'hF, 32'h0);
      tick();
      cmd_valid = 1'b0;
      for (int i = 0; i < 6; i++) begin
         chk("ack7_cyc_high", 64'(wbm_cyc), 64'd1);
         tick();
      end
      chk("ack7_cyc_7th", 64'(wbm_cyc), 64'd1);
      wbm_ack    = 1'b1;
      wbm_rd_dat = 32'h0BAD_C0DE;
      tick();
      wbm_ack = 1'b0;
      chk("ack7_err", 64'(rsp_err), 64'd0);
      chk("ack7_rdat", 64'(rsp_rdat), 64'h0BAD_C0DE);
      chk("ack7_valid", 64'(rsp_valid), 64'd1);
      rsp_ready = 1'b1;
      tick();
      rsp_ready = 1'b0;

      // Reset pulse mid-BUS
      put_cmd(1'b1, 17'h00020, 4'hC, 32'hCAFE_0001);
      tick();
      cmd_valid = 1'b0;
      chk("rstmid_cyc_before", 64'(wbm_cyc), 64'd1);
      #2;
      rst_n = 1'b0;
      #1;
      chk("rstmid_cyc_async", 64'(wbm_cyc), 64'd0);
      chk("rstmid_stb_async", 64'(wbm_stb), 64'd0);
      chk("rstmid_ready_low", 64'(cmd_ready), 64'd0);
      tick();
      rst_n = 1'b1;
      chk("rstmid_no_rsp", 64'(rsp_valid), 64'd0);
      tick();
      chk("rstmid_ready_after", 64'(cmd_ready), 64'd1);
      chk("rstmid_still_no_rsp", 64'(rsp_valid), 64'd0);
      put_cmd(1'b1, 17'h00024, 4'hF, 32'hCAFE_0002);
      tick();
      cmd_valid = 1'b0;
      chk("rstmid_next_adr", 64'(wbm_adr), 64'h24);
      wbm_ack = 1'b1;
      tick();
      wbm_ack = 1'b0;
      chk("rstmid_next_valid", 64'(rsp_valid), 64'd1);
      chk("rstmid_next_err", 64'(rsp_err), 64'd0);
      rsp_ready = 1'b1;
      tick();

      // Back-to-back writes, responder always ACKing, rsp_ready held high
      wbm_ack = 1'b1;
      for (int k = 0; k < 3; k++) begin
         chk("b2b_idle_ready", 64'(cmd_ready), 64'd1);
         put_cmd(1'b1, AW'(17'h00100 + 4 * k), 4'hF, 32'hA000_0000 + 32'(k));
         tick();
         chk("b2b_cyc", 64'(wbm_cyc), 64'd1);
         chk("b2b_adr", 64'(wbm_adr), 64'(17'h00100 + 4 * k));
         chk("b2b_dat", 64'(wbm_wr_dat), 64'(32'hA000_0000 + 32'(k)));
         tick();
         chk("b2b_resp_cyc", 64'(wbm_cyc), 64'd0);
         chk("b2b_resp_valid", 64'(rsp_valid), 64'd1);
         chk("b2b_resp_ready", 64'(cmd_ready), 64'd0);
         tick();
         chk("b2b_idle_cyc", 64'(wbm_cyc), 64'd0);
         chk("b2b_idle_rsp", 64'(rsp_valid), 64'd0);
      end
      cmd_valid = 1'b0;
      wbm_ack   = 1'b0;
      rsp_ready = 1'b0;
      tick();
      chk("final_state", 64'(dbg_state), 64'(ST_IDLE));
      chk("final_adr", 64'(wbm_adr), 64'h108);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule : tb_wb_cmd_master

// File: doc/wb_cmd_master.md
WB_CMD_MASTER -- requirements
Module: wb_cmd_master

Interface
REQ-001 Parameter ADDRWIDTH, default 17, SHALL set the Wishbone byte-address width.
REQ-002 Parameter DATAWIDTH, default 32, SHALL set the data width; byte strobes are DATAWIDTH/8 bits.
REQ-003 Parameter TIMEOUT_CYCLES, default 7, SHALL set the number of un-ACKed cycles (1-255) before abort.
REQ-004 Parameter ERR_READ_VALUE, default 32'hBAD_FAB_AC, SHALL be the read data returned on timeout.
REQ-005 Clock and reset SHALL be: one clock; reset is asynchronous and active-low. Ports: WB_CLK in 1 (sole clock, rising edge), WB_RST_n in 1 (async active-low reset).
REQ-006 cmd_valid  in  1  command offered.
REQ-007 cmd_ready  out  1  command accepted when high with cmd_valid.
REQ-008 cmd_we  in  1  1=write, 0=read.
REQ-009 cmd_adr  in  ADDRWIDTH  byte address.
REQ-010 cmd_be  in  DATAWIDTH/8  byte enables.
REQ-011 cmd_wdat  in  DATAWIDTH  write data.
REQ-012 rsp_valid  out  1  response available.
REQ-013 rsp_ready  in  1  response consumed when high with rsp_valid.
REQ-014 rsp_rdat  out  DATAWIDTH  read data (undefined for writes).
REQ-015 rsp_err  out  1  transaction timed out.
REQ-016 WBm_ADR out ADDRWIDTH, WBm_CYC out 1, WBm_STB out 1, WBm_WE out 1, WBm_RD out 1, WBm_BYTE_STB out DATAWIDTH/8, WBm_WR_DAT out DATAWIDTH: Wishbone initiator outputs, all registered.
REQ-017 WBm_RD_DAT in DATAWIDTH, WBm_ACK in 1: Wishbone responder returns.

Function
REQ-018 FSM states SHALL be IDLE, BUS, RESP; cmd_ready SHALL be 1 only in IDLE.
REQ-019 IDLE: on cmd_valid&cmd_ready, latch cmd_* and go to BUS; WBm_CYC=WBm_STB=1 from the next cycle (1-cycle issue latency).
REQ-020 BUS: WBm_ADR/WE/BYTE_STB/WR_DAT SHALL hold the latched values; WBm_RD = ~cmd_we latched; all stable until termination.
REQ-021 BUS with WBm_ACK=1: capture WBm_RD_DAT into rsp_rdat (reads only), rsp_err=0, go to RESP; CYC/STB/RD deassert next cycle.
REQ-022 Timeout counter SHALL clear on BUS entry and increment each BUS cycle without ACK; when it reaches TIMEOUT_CYCLES, abort: rsp_rdat=ERR_READ_VALUE, rsp_err=1, go to RESP.
REQ-023 ACK in the same cycle as the timeout condition SHALL win (normal completion, rsp_err=0).
REQ-024 RESP: rsp_valid=1, rsp_rdat/rsp_err stable until rsp_valid&rsp_ready; then go to IDLE (no same-cycle new command; minimum 3 cycles per transaction).
REQ-025 WBm_ACK outside BUS SHALL be ignored; cmd_valid outside IDLE SHALL be ignored (not latched).
REQ-026 Only one transaction SHALL be outstanding; no bursts, no pipelining.
REQ-027 When idle, WBm_CYC, WBm_STB, WBm_WE, WBm_RD SHALL be 0; WBm_ADR/WR_DAT/BYTE_STB SHALL hold their last values.

Reset
REQ-028 WB_RST_n low SHALL asynchronously force IDLE, counter=0, all WBm_* outputs=0, rsp_valid=0, rsp_err=0, rsp_rdat=0, cmd_ready=0 while asserted.
REQ-029 Reset mid-transaction SHALL drop CYC/STB immediately and discard the transaction without a response; cmd_ready=1 on the first clock after release.

Structure
REQ-030 Shared package wb_pkg SHALL hold the FSM state encoding, the default ADDRWIDTH/DATAWIDTH, and ERR_READ_VALUE.
REQ-031 Timeout counter SHALL be one sub-module, wb_ack_timer (clear, enable, expired outputs); everything else flat.

Verification
REQ-032 Write adr=17'h00008, be=4'hF, wdat=32'h1234_5678, responder ACKs 2nd BUS cycle -> CYC/STB high exactly 2 cycles, WE=1, rsp_valid with rsp_err=0.
REQ-033 Read adr=17'h00000, responder ACKs with RD_DAT=32'hFAB_DEF_AC -> rsp_rdat=32'hFAB_DEF_AC, rsp_err=0, RD=1 during BUS.
REQ-034 Read with no ACK, TIMEOUT_CYCLES=7 -> CYC drops after 7 BUS cycles, rsp_rdat=32'hBAD_FAB_AC, rsp_err=1; ACK on the 7th cycle instead -> rsp_err=0.
REQ-035 rsp_ready held low 10 cycles -> rsp_valid/rsp_rdat held, cmd_ready=0, extra cmd_valid and stray ACKs ignored.
REQ-036 WB_RST_n pulsed low mid-BUS -> CYC/STB=0 within the same cycle, no rsp_valid, next command completes normally.
REQ-037 Back-to-back commands with rsp_ready=1 -> 3-cycle spacing, addresses/data in order, no overlapping CYC.
